opcode_issuer: RTL
==================

# opcode_issuer

Issue stage that buffers fetched 32-bit instruction words and presents their opcode fields, one at a time, to the downstream opcode-decoding control units. Each presented opcode is held until a decoder acknowledges it with its enable strobe, or until a timeout expires, in which case the opcode is flagged illegal. It is the producer side of the opcode-match/enable-strobe path: the block drives the `in1`-style opcode bus that the control units decode and consumes the strobes they return.

## Interface
- `DEPTH`, 4: instruction buffer entries; power of two, at least 2.
- `TIMEOUT`, 4: maximum cycles an opcode is presented without an ack; at least 1.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset; synchronous, active-low.
- `instr_in` input 32: instruction word to buffer.
- `instr_valid` input 1: `instr_in` is valid this cycle.
- `instr_ready` output 1: buffer can accept a word this cycle.
- `opcode` output 6: `instr[31:26]` of the head entry; forced to 6'b000000 when `issue_valid` is low.
- `operand` output 26: `instr[25:0]` of the head entry; forced to 0 when `issue_valid` is low.
- `issue_valid` output 1: `opcode` and `operand` are being presented.
- `ack` input 1: enable strobe returned by the decoders.
- `retired` output 1: one-cycle pulse; the presented instruction was acked.
- `illegal` output 1: one-cycle pulse; the presented instruction timed out.
- `count` output 3: buffer occupancy, 0 to `DEPTH`.

## Operation
- The FIFO is a circular buffer with separate read and write pointers that wrap modulo `DEPTH`.
- Push: a word is written when `instr_valid && instr_ready` at the edge.
- `instr_ready` = `rst_n && (count < DEPTH)`. A pop in the same cycle does not free a slot for a push. A push and a pop in the same cycle leave `count` unchanged.
- The FSM has three states:
  - IDLE: `issue_valid` = 0. Moves to PRESENT when `count > 0`.
  - PRESENT: `issue_valid` = 1. The timer clears on entry and increments every cycle.
    - If `ack` = 1 at an edge: pop the head, set `retired`, move to GAP.
    - Otherwise, if timer == `TIMEOUT-1`: pop the head, set `illegal`, move to GAP.
    - If `ack` and timeout occur at the same edge, `ack` wins: `retired` = 1, `illegal` = 0.
  - GAP: `issue_valid` = 0 for exactly one cycle, so the decoders see the opcode return to 0 between instructions. `retired` or `illegal` is high in this cycle only. Moves to PRESENT if `count > 0`, otherwise to IDLE.
- `ack` is ignored in IDLE and GAP.
- Instructions issue in strict FIFO order.

## Timing
- Reset (`rst_n` low at an edge) applies the following values from that edge:
  - `count` = 0, pointers = 0, state = IDLE, timer = 0.
  - `issue_valid` = 0, `opcode` = 0, `operand` = 0, `retired` = 0, `illegal` = 0.
  - `instr_ready` = 0 while `rst_n` is low; 1 after release.
  - Buffered words are discarded, including during PRESENT.
- Latency: a word pushed into an empty buffer at edge k is presented (`issue_valid` = 1) after edge k+1.
- Per-instruction occupancy:
  - 1 to `TIMEOUT` cycles in PRESENT, plus 1 GAP cycle.
  - Back-to-back issue rate with an immediate ack is one instruction per 2 cycles.
- All outputs are registered except `instr_ready`. `opcode` and `operand` are muxed from registered state.

## Configuration
- `OPCODE_ISSUER_STATS_EN` defined: adds output ports `retired_cnt` [15:0] and `illegal_cnt` [15:0].
  - Each counter increments on its pulse and saturates at 16'hFFFF.
  - Both clear on reset.
- Macro undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n` low 2 cycles with `instr_valid` = 1 → all outputs 0, `instr_ready` = 0, nothing buffered. After release, `instr_ready` = 1 and `count` = 0.
- Ack path: push 32'h24020005 and assert `ack` on the 2nd PRESENT cycle → `opcode` = 6'b001001 and `operand` = 26'h0020005 for exactly 2 cycles, then `retired` = 1 for one cycle, `illegal` = 0, `count` = 0.
- Timeout path: push 32'h8C430000 with `ack` = 0 and `TIMEOUT` = 4 → `opcode` = 6'b100011 for exactly 4 cycles, then `illegal` = 1 for one cycle, then IDLE.
- Full buffer: with `ack` = 0 and `DEPTH` = 4, offer 5 distinct words back-to-back → 4 are accepted on consecutive edges; the 5th is held with `instr_ready` = 0 until the first timeout pop. All 5 issue in order, each separated by a GAP cycle.
- Simultaneous events: `ack` = 1 on the 4th (final) PRESENT cycle → `retired` = 1 and `illegal` = 0. `ack` pulses during GAP or IDLE → no effect.
- Mid-operation reset: drop `rst_n` during PRESENT with 3 words buffered → after that edge `issue_valid` = 0 and `count` = 0, no `retired` or `illegal` pulse, and the old words never reappear. With `OPCODE_ISSUER_STATS_EN` defined, both counters read 0.

Source files
------------

// File: rtl/opcode_issuer.sv
// opcode_issuer: issue stage between instruction fetch and the opcode decoders.
// Fetched words are buffered in a circular FIFO. The head word's opcode and
// operand are presented one at a time. A word leaves the FIFO when the
// decoders return ack (retired) or when it has been presented for TIMEOUT
// cycles without an ack (illegal). After each word there is one GAP cycle in
// which the opcode bus reads zero.
//
// Parameters: DEPTH   FIFO entries (power of two, >= 2)
//             TIMEOUT max cycles a word is presented without ack (>= 1)
// Ports:      clk, rst_n        clock, synchronous active-low reset
//             instr_in/valid    word offered by fetch; instr_ready = slot free
//             opcode/operand    head word fields, zero when issue_valid low
//             issue_valid       opcode/operand being presented
//             ack               enable strobe from the decoders
//             retired/illegal   one-cycle pulses (GAP cycle) after ack/timeout
//             count             FIFO occupancy, 0..DEPTH
// Optional:   `define OPCODE_ISSUER_STATS_EN adds saturating 16-bit
//             retired_cnt / illegal_cnt outputs.
module opcode_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             instr_in,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  output logic [5:0]              opcode,
  output logic [25:0]             operand,
  output logic                    issue_valid,
  input  logic                    ack,
  output logic                    retired,
  output logic                    illegal,
  output logic [$clog2(DEPTH):0]  count
`ifdef OPCODE_ISSUER_STATS_EN
  ,
  output logic [15:0]             retired_cnt,
  output logic [15:0]             illegal_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            retired_q, retired_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     mem_q [DEPTH];
  logic            push, pop;

  // Ready looks only at the registered occupancy, so a pop in the same cycle
  // never makes room for a push.
  assign instr_ready = rst_n && (count_q < CW'(DEPTH));
  assign push        = instr_valid && instr_ready;
  assign count_d     = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pop       = 1'b0;
    retired_d = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = PRESENT;
          timer_d = '0;
        end
      end
      PRESENT: begin
        timer_d = timer_q + TW'(1);
        // ack has priority over a timeout on the same edge
        if (ack) begin
          pop       = 1'b1;
          retired_d = 1'b1;
          state_d   = GAP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          pop       = 1'b1;
          illegal_d = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        // count_q already reflects the pop of the word just finished
        if (count_q != '0) begin
          state_d = PRESENT;
          timer_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      retired_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // Storage needs no reset: entries are only visible through count/rptr.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= instr_in;
  end

  assign issue_valid = (state_q == PRESENT);
  assign opcode      = issue_valid ? mem_q[rptr_q][31:26] : 6'd0;
  assign operand     = issue_valid ? mem_q[rptr_q][25:0]  : 26'd0;
  assign retired     = retired_q;
  assign illegal     = illegal_q;
  assign count       = count_q;

`ifdef OPCODE_ISSUER_STATS_EN
  logic [15:0] retired_cnt_q, illegal_cnt_q;

  // Counted on the edge that raises the pulse; saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (retired_d && retired_cnt_q != 16'hFFFF) retired_cnt_q <= retired_cnt_q + 16'd1;
      if (illegal_d && illegal_cnt_q != 16'hFFFF) illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
